// File: rtl/seg7_readback.sv
// seg7_readback: reads back active-low HEX segment patterns, waits for the
// bus to settle, decodes one digit per cycle and offers the assembled value
// (plus per-digit invalid flags) on a valid/ready handshake.
module seg7_readback #(
   parameter int NUM_DIGITS    = 6,
   parameter int STABLE_CYCLES = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7*NUM_DIGITS-1:0] seg_in,
   input  logic                    start,
   output logic [4*NUM_DIGITS-1:0] out_value,
   output logic [NUM_DIGITS-1:0]   out_invalid,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    busy
);

   localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_STABLE, S_SCAN, S_HOLD} state_t;

   state_t                     r_state, w_next_state;
   logic [NUM_DIGITS-1:0][6:0] r_snap;
   logic [CNT_W-1:0]           r_cnt;
   logic [IDX_W-1:0]           r_idx;
   logic [NUM_DIGITS-1:0][3:0] r_shadow_val, w_shadow_val;
   logic [NUM_DIGITS-1:0]      r_shadow_inv, w_shadow_inv;
   logic [NUM_DIGITS-1:0][3:0] r_out_value;
   logic [NUM_DIGITS-1:0]      r_out_invalid;
   logic                       r_out_valid;
   logic [6:0]                 w_digit;
   logic [3:0]                 w_nib;
   logic                       w_bad;
   logic                       w_seg_same, w_stable, w_last;

   // Active-low gfedcba pattern -> {invalid, nibble}; unknown shapes decode as 0.
   function automatic logic [4:0] decode_seg(input logic [6:0] seg);
      case (seg)
         7'b1000000: return 5'h00;
         7'b1111001: return 5'h01;
         7'b0100100: return 5'h02;
         7'b0110000: return 5'h03;
         7'b0011001: return 5'h04;
         7'b0010010: return 5'h05;
         7'b0000010: return 5'h06;
         7'b1111000: return 5'h07;
         7'b0000000: return 5'h08;
         7'b0010000: return 5'h09;
         7'b0001000: return 5'h0A;
         7'b0000011: return 5'h0B;
         7'b1000110: return 5'h0C;
         7'b0100001: return 5'h0D;
         7'b0000110: return 5'h0E;
         7'b0001110: return 5'h0F;
         default:    return 5'h10;
      endcase
   endfunction

   assign w_seg_same = (seg_in == r_snap);
   assign w_stable   = w_seg_same && (r_cnt == CNT_LAST);
   assign w_last     = (r_idx == IDX_LAST);

   // Decode the current snapshot digit and merge it into the shadow copy.
   always_comb begin
      w_digit          = r_snap[r_idx];
      {w_bad, w_nib}   = decode_seg(w_digit);
      w_shadow_val     = r_shadow_val;
      w_shadow_inv     = r_shadow_inv;
      w_shadow_val[r_idx] = w_nib;
      w_shadow_inv[r_idx] = w_bad;
   end

   // Next-state logic.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:        if (start)                      w_next_state = S_WAIT_STABLE;
         S_WAIT_STABLE: if (w_stable)                   w_next_state = S_SCAN;
         S_SCAN:        if (w_last)                     w_next_state = S_HOLD;
         S_HOLD:        if (r_out_valid && out_ready)   w_next_state = S_IDLE;
         default:                                       w_next_state = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Snapshot, stability counter, scan index, shadow and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_snap        <= '0;
         r_cnt         <= '0;
         r_idx         <= '0;
         r_shadow_val  <= '0;
         r_shadow_inv  <= '0;
         r_out_value   <= '0;
         r_out_invalid <= '0;
         r_out_valid   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_snap <= seg_in;
                  r_cnt  <= '0;
               end
            end
            S_WAIT_STABLE: begin
               // Any change restarts the window against the new pattern.
               if (!w_seg_same) begin
                  r_snap <= seg_in;
                  r_cnt  <= '0;
               end else if (r_cnt != CNT_LAST) begin
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_idx <= '0;
               end
            end
            S_SCAN: begin
               r_shadow_val <= w_shadow_val;
               r_shadow_inv <= w_shadow_inv;
               r_idx        <= r_idx + 1'b1;
               if (w_last) begin
                  r_out_value   <= w_shadow_val;
                  r_out_invalid <= w_shadow_inv;
                  r_out_valid   <= 1'b1;
               end
            end
            S_HOLD: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out_value   = r_out_value;
   assign out_invalid = r_out_invalid;
   assign out_valid   = r_out_valid;
   assign busy        = (r_state != S_IDLE);

endmodule
